// File: rtl/rv32_mod_pc_gen.sv
// rv32_mod_pc_gen: fetch PC generator with prioritised, stall-buffered redirects.
// Latency: a redirect is applied one cycle after the deciding edge (unstalled) or one edge after stall release.
// Backpressure: the PC advances only on pc_valid && pc_ready. stall freezes the PC and buffers any redirect.
//
// Ports:
//   clk, reset (async, active-high), stall
//   pc_valid/pc_ready/pc_current : fetch handshake and registered PC
//   pc_next                      : sequential successor of pc_current (+2 or +4)
//   is_compressed                : instruction at pc_current is 16-bit
//   redirect_valid/target        : NUM_REDIRECT channels, index 0 has the highest priority
//   redirect_taken, flush        : one-cycle pulses for an applied redirect
//   misaligned, misaligned_addr  : one-cycle pulse and sticky address of a rejected target
//
// Build option: define RV32_PC_COMPRESSED_EN to honour is_compressed and allow
// 2-byte aligned targets. Without it, the step is always 4 and targets need [1:0]==0.
module rv32_mod_pc_gen #(
   parameter int unsigned XLEN         = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h1000_0000,
   parameter int unsigned NUM_REDIRECT = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   output logic                         pc_valid,
   input  logic                         pc_ready,
   output logic [XLEN-1:0]              pc_current,
   output logic [XLEN-1:0]              pc_next,
   input  logic                         is_compressed,
   input  logic [NUM_REDIRECT-1:0]      redirect_valid,
   input  logic [NUM_REDIRECT*XLEN-1:0] redirect_target,
   output logic [NUM_REDIRECT-1:0]      redirect_taken,
   output logic                         flush,
   output logic                         misaligned,
   output logic [XLEN-1:0]              misaligned_addr
);

   localparam int unsigned IDXW = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND, S_HALT} state_t;

   state_t                  state_q, state_d;
   logic [XLEN-1:0]         pc_q, pc_d;
   logic [XLEN-1:0]         pend_tgt_q, pend_tgt_d;
   logic [IDXW-1:0]         pend_idx_q, pend_idx_d;
   logic [NUM_REDIRECT-1:0] taken_q, taken_d;
   logic                    flush_q, flush_d;
   logic                    mis_q, mis_d;
   logic [XLEN-1:0]         mis_addr_q, mis_addr_d;

   logic                    sel_vld;
   logic [IDXW-1:0]         sel_idx;
   logic [XLEN-1:0]         sel_tgt;
   logic                    cand_vld;
   logic                    cand_new;
   logic [IDXW-1:0]         cand_idx;
   logic [XLEN-1:0]         cand_tgt;
   logic                    cand_mis;
   logic                    apply;

`ifdef RV32_PC_COMPRESSED_EN
   assign pc_next  = pc_q + (is_compressed ? XLEN'(2) : XLEN'(4));
   assign cand_mis = cand_tgt[0];
`else
   logic unused_is_compressed;
   assign unused_is_compressed = is_compressed;
   assign pc_next  = pc_q + XLEN'(4);
   assign cand_mis = |cand_tgt[1:0];
`endif

   // Walk from the lowest priority upward so the lowest valid index is left standing.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      sel_tgt = '0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         if (redirect_valid[i]) begin
            sel_vld = 1'b1;
            sel_idx = IDXW'(i);
            sel_tgt = redirect_target[i*XLEN +: XLEN];
         end
      end
   end

   // While a redirect is buffered, a new one replaces it on equal or higher priority
   // (equal index: the newer target wins).
   assign cand_new = sel_vld && ((state_q != S_PEND) || (sel_idx <= pend_idx_q));
   assign cand_vld = sel_vld || (state_q == S_PEND);
   assign cand_tgt = cand_new ? sel_tgt : pend_tgt_q;
   assign cand_idx = cand_new ? sel_idx : pend_idx_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      pend_idx_d = pend_idx_q;
      flush_d    = 1'b0;
      taken_d    = '0;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      apply      = 1'b0;

      case (state_q)
         S_BOOT: state_d = S_RUN;
         default: begin
            if (stall) begin
               if (cand_vld) begin
                  pend_tgt_d = cand_tgt;
                  pend_idx_d = cand_idx;
                  state_d    = S_PEND;
               end
            end else if (cand_vld) begin
               // A redirect wins over the handshake: the offered PC is dropped.
               apply = 1'b1;
            end else if ((state_q == S_RUN) && pc_ready) begin
               pc_d = pc_next;
            end
         end
      endcase

      if (apply) begin
         if (cand_mis) begin
            mis_d      = 1'b1;
            mis_addr_d = cand_tgt;
            state_d    = S_HALT;
         end else begin
            pc_d    = cand_tgt;
            flush_d = 1'b1;
            state_d = S_RUN;
         end
      end

      for (int i = 0; i < NUM_REDIRECT; i++) begin
         taken_d[i] = apply && !cand_mis && (cand_idx == IDXW'(i));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_BOOT;
         pc_q       <= XLEN'(RESET_VECTOR);
         pend_tgt_q <= '0;
         pend_idx_q <= '0;
         taken_q    <= '0;
         flush_q    <= 1'b0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_idx_q <= pend_idx_d;
         taken_q    <= taken_d;
         flush_q    <= flush_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign pc_valid        = (state_q == S_RUN);
   assign pc_current      = pc_q;
   assign redirect_taken  = taken_q;
   assign flush           = flush_q;
   assign misaligned      = mis_q;
   assign misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_rv32_mod_pc_gen.sv
// Directed bench for rv32_mod_pc_gen: reset, sequential advance, priority
// redirect, stalled/buffered redirect, misalignment halt and recovery, wrap,
// and reset while a redirect is buffered.
module tb_rv32_mod_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        pc_valid;
   logic        pc_ready;
   logic [31:0] pc_current;
   logic [31:0] pc_next;
   logic        is_compressed;
   logic [2:0]  redirect_valid;
   logic [95:0] redirect_target;
   logic [2:0]  redirect_taken;
   logic        flush;
   logic        misaligned;
   logic [31:0] misaligned_addr;

   int nchk = 0;
   int nerr = 0;

   rv32_mod_pc_gen dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .pc_valid        (pc_valid),
      .pc_ready        (pc_ready),
      .pc_current      (pc_current),
      .pc_next         (pc_next),
      .is_compressed   (is_compressed),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .redirect_taken  (redirect_taken),
      .flush           (flush),
      .misaligned      (misaligned),
      .misaligned_addr (misaligned_addr)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_redir(input logic [2:0] v, input logic [31:0] t0,
                            input logic [31:0] t1, input logic [31:0] t2);
      redirect_valid  = v;
      redirect_target = {t2, t1, t0};
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; pc_ready = 1'b0; is_compressed = 1'b0;
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      tick(); tick();
      nchk++; if (pc_current !== 32'h1000_0000) begin nerr++; $display("FAIL reset_pc got=%h exp=%h", pc_current, 32'h1000_0000); end
      nchk++; if (pc_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
      nchk++; if ({flush, misaligned, redirect_taken} !== 5'b0) begin nerr++; $display("FAIL reset_pulses got=%b exp=00000", {flush, misaligned, redirect_taken}); end
      nchk++; if (misaligned_addr !== 32'h0) begin nerr++; $display("FAIL reset_maddr got=%h exp=0", misaligned_addr); end
   endtask

   task automatic test_sequential();
      logic [31:0] e1, e2, e3;
`ifdef RV32_PC_COMPRESSED_EN
      e1 = 32'h1000_0004; e2 = 32'h1000_0006; e3 = 32'h1000_000A;
`else
      e1 = 32'h1000_0004; e2 = 32'h1000_0008; e3 = 32'h1000_000C;
`endif
      reset = 1'b0; pc_ready = 1'b1; is_compressed = 1'b0;
      // Still in BOOT until the first edge after release.
      #1;
      nchk++; if (pc_valid !== 1'b0) begin nerr++; $display("FAIL boot_valid got=%b exp=0", pc_valid); end
      tick();
      nchk++; if (pc_valid !== 1'b1 || pc_current !== 32'h1000_0000) begin nerr++; $display("FAIL run_first got=%b/%h exp=1/10000000", pc_valid, pc_current); end
      tick();
      nchk++; if (pc_current !== e1) begin nerr++; $display("FAIL seq1 got=%h exp=%h", pc_current, e1); end
      is_compressed = 1'b1; #1;
      nchk++; if (pc_next !== e2) begin nerr++; $display("FAIL pc_next_c got=%h exp=%h", pc_next, e2); end
      tick();
      nchk++; if (pc_current !== e2) begin nerr++; $display("FAIL seq2 got=%h exp=%h", pc_current, e2); end
      is_compressed = 1'b0;
      tick();
      nchk++; if (pc_current !== e3) begin nerr++; $display("FAIL seq3 got=%h exp=%h", pc_current, e3); end
      pc_ready = 1'b0;
      tick(); tick();
      nchk++; if (pc_current !== e3 || pc_valid !== 1'b1) begin nerr++; $display("FAIL hold_noready got=%h/%b exp=%h/1", pc_current, pc_valid, e3); end
   endtask

   task automatic test_redirect_priority();
      pc_ready = 1'b1;
      set_redir(3'b110, 32'h0, 32'h200, 32'h300);
      tick();
      nchk++; if (pc_current !== 32'h200) begin nerr++; $display("FAIL redir_pc got=%h exp=200", pc_current); end
      nchk++; if (redirect_taken !== 3'b010 || flush !== 1'b1) begin nerr++; $display("FAIL redir_pulse got=%b/%b exp=010/1", redirect_taken, flush); end
      nchk++; if (pc_valid !== 1'b1) begin nerr++; $display("FAIL redir_valid got=%b exp=1", pc_valid); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      nchk++; if (flush !== 1'b0 || redirect_taken !== 3'b000) begin nerr++; $display("FAIL redir_pulse_end got=%b/%b exp=0/000", flush, redirect_taken); end
      nchk++; if (pc_current !== 32'h204) begin nerr++; $display("FAIL redir_advance got=%h exp=204", pc_current); end
   endtask

   task automatic test_stalled_pending();
      pc_ready = 1'b0; stall = 1'b1;
      set_redir(3'b100, 32'h0, 32'h0, 32'h300);
      tick();
      nchk++; if (pc_valid !== 1'b0 || pc_current !== 32'h204) begin nerr++; $display("FAIL pend_enter got=%b/%h exp=0/204", pc_valid, pc_current); end
      set_redir(3'b001, 32'h100, 32'h0, 32'h0);
      tick();
      set_redir(3'b010, 32'h0, 32'h180, 32'h0);
      tick();
      nchk++; if (flush !== 1'b0 || pc_current !== 32'h204) begin nerr++; $display("FAIL pend_stalled got=%b/%h exp=0/204", flush, pc_current); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      stall = 1'b0;
      tick();
      nchk++; if (pc_current !== 32'h100) begin nerr++; $display("FAIL pend_apply_pc got=%h exp=100", pc_current); end
      nchk++; if (redirect_taken !== 3'b001 || flush !== 1'b1 || pc_valid !== 1'b1) begin nerr++; $display("FAIL pend_apply_pulse got=%b/%b/%b exp=001/1/1", redirect_taken, flush, pc_valid); end
      tick();
      nchk++; if (flush !== 1'b0 || pc_current !== 32'h100) begin nerr++; $display("FAIL pend_after got=%b/%h exp=0/100", flush, pc_current); end
   endtask

   task automatic test_misaligned();
      logic [31:0] bad;
`ifdef RV32_PC_COMPRESSED_EN
      bad = 32'h101;
`else
      bad = 32'h102;
`endif
      pc_ready = 1'b1;
      set_redir(3'b001, bad, 32'h0, 32'h0);
      tick();
      nchk++; if (misaligned !== 1'b1 || misaligned_addr !== bad) begin nerr++; $display("FAIL mis_pulse got=%b/%h exp=1/%h", misaligned, misaligned_addr, bad); end
      nchk++; if (pc_valid !== 1'b0 || flush !== 1'b0 || pc_current !== 32'h100) begin nerr++; $display("FAIL mis_state got=%b/%b/%h exp=0/0/100", pc_valid, flush, pc_current); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      tick(); tick();
      nchk++; if (misaligned !== 1'b0 || pc_valid !== 1'b0 || misaligned_addr !== bad) begin nerr++; $display("FAIL halt_hold got=%b/%b/%h exp=0/0/%h", misaligned, pc_valid, misaligned_addr, bad); end
      nchk++; if (pc_current !== 32'h100) begin nerr++; $display("FAIL halt_pc got=%h exp=100", pc_current); end
      set_redir(3'b010, 32'h0, 32'h104, 32'h0);
      tick();
      nchk++; if (pc_current !== 32'h104 || pc_valid !== 1'b1 || flush !== 1'b1) begin nerr++; $display("FAIL recover got=%h/%b/%b exp=104/1/1", pc_current, pc_valid, flush); end
      nchk++; if (redirect_taken !== 3'b010) begin nerr++; $display("FAIL recover_taken got=%b exp=010", redirect_taken); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_wrap();
      logic [31:0] nc;
`ifdef RV32_PC_COMPRESSED_EN
      nc = 32'hFFFF_FFFE;
`else
      nc = 32'h0;
`endif
      pc_ready = 1'b0;
      set_redir(3'b100, 32'h0, 32'h0, 32'hFFFF_FFFC);
      tick();
      nchk++; if (pc_current !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_load got=%h exp=fffffffc", pc_current); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      is_compressed = 1'b1; #1;
      nchk++; if (pc_next !== nc) begin nerr++; $display("FAIL wrap_next_c got=%h exp=%h", pc_next, nc); end
      is_compressed = 1'b0; pc_ready = 1'b1;
      tick();
      nchk++; if (pc_current !== 32'h0) begin nerr++; $display("FAIL wrap got=%h exp=0", pc_current); end
   endtask

   task automatic test_reset_in_pend();
      pc_ready = 1'b0; stall = 1'b1;
      set_redir(3'b001, 32'h500, 32'h0, 32'h0);
      tick();
      nchk++; if (pc_valid !== 1'b0) begin nerr++; $display("FAIL rp_pend got=%b exp=0", pc_valid); end
      reset = 1'b1; #1;
      nchk++; if (pc_current !== 32'h1000_0000 || pc_valid !== 1'b0) begin nerr++; $display("FAIL rp_async got=%h/%b exp=10000000/0", pc_current, pc_valid); end
      set_redir(3'b000, 32'h0, 32'h0, 32'h0);
      stall = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      nchk++; if (pc_valid !== 1'b1 || pc_current !== 32'h1000_0000 || flush !== 1'b0) begin nerr++; $display("FAIL rp_boot got=%b/%h/%b exp=1/10000000/0", pc_valid, pc_current, flush); end
      tick(); tick();
      nchk++; if (pc_current !== 32'h1000_0000 || redirect_taken !== 3'b000) begin nerr++; $display("FAIL rp_discard got=%h/%b exp=10000000/000", pc_current, redirect_taken); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect_priority();
      test_stalled_pending();
      test_misaligned();
      test_wrap();
      test_reset_in_pend();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rv32_mod_pc_gen.md
# rv32_mod_pc_gen

Parametrised program-counter generator for the rv32imc_ss fetch front end. Holds the architectural fetch PC, offers it to fetch over a valid/ready handshake, and advances it by 2 or 4 bytes. Arbitrates up to `NUM_REDIRECT` prioritised redirect sources (trap, branch, jump, …) and buffers a redirect that arrives while the pipeline is stalled. Detects misaligned redirect targets and halts fetch until a corrective redirect arrives.

## Interface
Parameters:
- `XLEN`, 32, PC width in bits.
- `RESET_VECTOR`, `32'h10000000` (zero-extended to `XLEN`), PC after reset.
- `NUM_REDIRECT`, 3, number of redirect channels (1..8). Index 0 has the highest priority.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline freeze; PC and handshake state hold.
- `pc_valid` out 1: `pc_current` is offered to fetch.
- `pc_ready` in 1: fetch accepts `pc_current` this cycle.
- `pc_current` out `XLEN`: current fetch PC (registered).
- `pc_next` out `XLEN`: combinational sequential successor of `pc_current`.
- `is_compressed` in 1: the instruction at `pc_current` is 16-bit.
- `redirect_valid` in `NUM_REDIRECT`: per-channel redirect request.
- `redirect_target` in `NUM_REDIRECT*XLEN`: channel i target in bits `[i*XLEN +: XLEN]`.
- `redirect_taken` out `NUM_REDIRECT`: registered one-hot of the channel applied; one-cycle pulse.
- `flush` out 1: registered one-cycle pulse in the cycle a redirect takes effect.
- `misaligned` out 1: registered one-cycle pulse when a selected target is misaligned.
- `misaligned_addr` out `XLEN`: offending target; holds its value until the next misalignment event.

## Operation
- States:
  - BOOT: the first cycle after reset release.
  - RUN: normal fetch.
  - PEND: a redirect is buffered.
  - HALT: fetch is stopped after a misaligned target.
- `pc_valid` is 1 only in RUN.
- Reset values: `pc_current`=`RESET_VECTOR`, state BOOT, `pc_valid`=0, `flush`=0, `misaligned`=0, `redirect_taken`=0, `misaligned_addr`=0, pending register=0.
- BOOT → RUN unconditionally on the next edge.
- `pc_next` = `pc_current` + (`is_compressed` ? 2 : 4), computed modulo 2^`XLEN`. `'1` wraps to 1 or 3.
- Selection: the lowest index i with `redirect_valid[i]`=1 is the selected channel.
- RUN, `stall`=0, any redirect:
  - Aligned target: load the target into `pc_current` and pulse `flush`/`redirect_taken`.
  - Misaligned target: PC unchanged, pulse `misaligned`, latch `misaligned_addr`, go to HALT.
  - A redirect overrides the handshake: the offered PC is discarded even if `pc_ready`=1.
- RUN, `stall`=0, no redirect, `pc_ready`=1: `pc_current` ← `pc_next`.
- RUN, `stall`=0, no redirect, `pc_ready`=0: hold.
- RUN or HALT, `stall`=1, any redirect: buffer the target and channel index, go to PEND. PC unchanged.
- RUN, `stall`=1, no redirect: hold everything.
- PEND, new redirect (stalled or not): the candidate replaces the buffered one if its index is ≤ the buffered index (tie: newer wins).
- PEND, `stall`=0: apply the winning candidate exactly as in RUN (aligned → RUN plus `flush`; misaligned → HALT plus `misaligned`).
- HALT, `stall`=0, redirect: handled as in RUN (recovers to RUN, or re-pulses `misaligned`). Without a redirect, HALT holds.
- `reset` asserted at any time returns all state to the reset values immediately, discarding any buffered redirect.

## Timing
- Redirect at edge n (unstalled): `pc_current`=target, `flush`=1, `redirect_taken`=one-hot during cycle n+1. `pc_valid`=1 in n+1.
- Sequential advance: one PC per accepted handshake, zero bubbles.
- Stalled redirect: applied on the first edge with `stall`=0, giving 1-cycle latency from stall release.
- Misaligned: `misaligned`=1 for exactly one cycle; `pc_valid`=0 from the next cycle until recovery.
- No combinational path from `redirect_*` to any output.

## Configuration
- `RV32_PC_COMPRESSED_EN` defined:
  - `is_compressed` is honoured.
  - A target is misaligned iff bit 0 = 1.
- `RV32_PC_COMPRESSED_EN` undefined:
  - `is_compressed` is ignored and `pc_next` = `pc_current` + 4.
  - A target is misaligned iff bits [1:0] ≠ 0.

## Test plan
- Reset then release with `pc_ready`=1 and `is_compressed` pattern 0,1,0 → `pc_valid` rises after one BOOT cycle. PC sequence is `0x10000000`, `0x10000004`, `0x10000006`, `0x1000000A`.
- Unstalled redirects ch1=`0x200` and ch2=`0x300` in the same cycle → next cycle `pc_current`=`0x200`, `redirect_taken`=`3'b010`, `flush`=1 for one cycle.
- Redirect ch2=`0x300` under `stall`, then ch0=`0x100` under `stall`, then ch1=`0x180` under `stall`, then release → `pc_current`=`0x100` one cycle after release, `redirect_taken`=`3'b001`.
- Redirect to `0x101` (macro defined) → `misaligned`=1 for one cycle, `misaligned_addr`=`0x101`, `pc_valid`=0. Then redirect to `0x104` → RUN resumes with `pc_current`=`0x104`.
- Macro undefined, redirect to `0x102` → `misaligned`=1. With `pc_current`=`0xFFFFFFFC` and `pc_ready`=1 → `pc_current` wraps to `0x0`.
- Assert `reset` while in PEND → `pc_current`=`0x10000000` and `pc_valid`=0 immediately. After release, the buffered redirect is never applied.
